regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates three write requesters onto the single write port of a
// 4-entry register file. Acceptance (req_ready) is combinational and one-hot.
// The accepted write is registered and presented on wr_* one cycle later.
//
// Build option:
//   REGFILE_ARB_ROUND_ROBIN_EN - when defined, priority rotates and starts
//   just after the most recently granted requester. When undefined, priority
//   is fixed (0 > 1 > 2) and no pointer state exists.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    req_valid,
    output logic [2:0]                    req_ready,
    input  logic [3*ADDR_WIDTH-1:0]       req_reg,
    input  logic [3*DATA_WIDTH-1:0]       req_data,
    input  logic                          hold,
    output logic                          wr_enable,
    output logic [ADDR_WIDTH-1:0]         wr_reg,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [2:0]                    grant,
    output logic [(1<<ADDR_WIDTH)-1:0]    pending_mask
);

    localparam int NUM_REQ = 3;

    logic       found;
    logic [1:0] sel_idx;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Rotating-priority selection: search starts one past the last winner.
    always_comb begin : select_proc
        logic [1:0] cand;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req_ready = '0;
        sel_idx   = '0;
        found     = 1'b0;
        cand      = '0;
        if (!reset && !hold) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = 2'((int'(rr_ptr) + k) % NUM_REQ);
                if (!found && req_valid[cand]) begin
                    found     = 1'b1;
                    sel_idx   = cand;
                    req_ready = 3'(1 << cand);
                end
            end
        end
    end

    // Pointer remembers the last granted requester; moves only on a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 2'd2;
        end else if (found) begin
            rr_ptr <= sel_idx;
        end
    end
`else
    // Fixed-priority selection: lowest requester index wins.
    always_comb begin
        req_ready = '0;
        sel_idx   = '0;
        found     = 1'b0;
        if (!reset && !hold) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i]) begin
                    found     = 1'b1;
                    sel_idx   = 2'(i);
                    req_ready = 3'(1 << i);
                end
            end
        end
    end
`endif

    // Output stage: capture the accepted write; index and data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_enable <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            grant     <= '0;
        end else if (found) begin
            wr_enable <= 1'b1;
            wr_reg    <= req_reg[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data   <= req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            grant     <= req_ready;
        end else begin
            wr_enable <= 1'b0;
            grant     <= '0;
        end
    end

    // One-hot decode of the register being written this cycle.
    always_comb begin
        pending_mask = '0;
        if (wr_enable) begin
            pending_mask[wr_reg] = 1'b1;
        end
    end

endmodule
